// File: rtl/tdo_arb_pkg.sv
// Shared types, widths and the round-robin pick function for the TDO shift arbiter.
// Optional watchdog feature is enabled with the TDO_ARB_TIMEOUT_EN macro.
package tdo_arb_pkg;

  localparam int WORD_W_DEFAULT = 32;
  localparam int MAX_REQ        = 8;
  localparam int PTR_W          = 3;
  localparam int WDOG_W         = 6;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } arb_state_t;

  // Returns a one-hot vector of the first set request bit found when
  // scanning upward from ptr and wrapping at numReq. Zero if nothing set.
  function automatic logic [MAX_REQ-1:0] rrPickOnehot(
    input logic [MAX_REQ-1:0] reqVec,
    input logic [PTR_W-1:0]   ptr,
    input logic [PTR_W:0]     numReq
  );
    logic [MAX_REQ-1:0] result;
    logic [PTR_W:0]     idx;
    logic               found;
    result = '0;
    found  = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= numReq) begin
        idx = idx - numReq;
      end
      if (((PTR_W+1)'(i) < numReq) && !found && reqVec[idx[PTR_W-1:0]]) begin
        result[idx[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/tdo_shift_arbiter_if.sv
// Bus between the DR sources / serializer side and the TDO shift arbiter.
// The timeout_err signal only exists when TDO_ARB_TIMEOUT_EN is defined.
interface tdo_shift_arbiter_if
  import tdo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = WORD_W_DEFAULT
);

  logic                      shift_dr;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*WORD_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        ack;
  logic                      aborted;
  logic                      tx_enable;
  logic [WORD_W-1:0]         tx_data;
  logic                      tx_done;
  logic                      busy;
`ifdef TDO_ARB_TIMEOUT_EN
  logic                      timeout_err;
`endif

  // Arbiter side: consumes requests and the serializer done flag.
  modport slave (
    input  shift_dr, req, req_data, tx_done,
    output grant, ack, aborted, tx_enable, tx_data, busy
`ifdef TDO_ARB_TIMEOUT_EN
    , output timeout_err
`endif
  );

  // Requester / TAP / serializer side.
  modport master (
    output shift_dr, req, req_data, tx_done,
    input  grant, ack, aborted, tx_enable, tx_data, busy
`ifdef TDO_ARB_TIMEOUT_EN
    , input timeout_err
`endif
  );

endinterface

// File: rtl/rr_picker.sv
// Round-robin requester picker: holds the rotation pointer and computes the
// winning requester combinationally from the current request vector.
module rr_picker
  import tdo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk_tck,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [PTR_W-1:0]   advance_idx,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [PTR_W-1:0]   pick_idx,
  output logic               any
);

  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W-1:0]   r_rrPtr;
  logic [MAX_REQ-1:0] w_reqPad;
  logic [MAX_REQ-1:0] w_pick;

  // Pointer moves just past the requester whose word completed.
  always_ff @(posedge clk_tck) begin
    if (reset) begin
      r_rrPtr <= '0;
    end else if (advance) begin
      r_rrPtr <= (advance_idx == LAST_IDX) ? '0 : advance_idx + 1'b1;
    end
  end

  // Scan from the pointer with wrap-around and encode the winner.
  always_comb begin
    w_reqPad = MAX_REQ'(req);
    w_pick   = rrPickOnehot(w_reqPad, r_rrPtr, NUM_REQ_W);
    pick_idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (w_pick[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
    pick_onehot = w_pick[NUM_REQ-1:0];
    any         = |w_pick;
  end

endmodule

// File: rtl/tdo_shift_arbiter.sv
// Shares one TDO serializer between several DR sources with round-robin
// arbitration, word latching and enable/done sequencing in the TCK domain.
// Define TDO_ARB_TIMEOUT_EN to add the SHIFT watchdog and timeout_err output.
module tdo_shift_arbiter
  import tdo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = WORD_W_DEFAULT
`ifdef TDO_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 40
`endif
) (
  input  logic                clk_tck,
  input  logic                reset,
  tdo_shift_arbiter_if.slave  bus
);

  arb_state_t         r_state;
  arb_state_t         w_stateNext;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grantNext;
  logic [WORD_W-1:0]  r_txData;
  logic [WORD_W-1:0]  w_txDataNext;
  logic [PTR_W-1:0]   r_ownerIdx;
  logic [PTR_W-1:0]   w_ownerNext;
  logic               r_aborted;
  logic               w_abortedNext;

  logic [NUM_REQ-1:0] w_pickOnehot;
  logic [PTR_W-1:0]   w_pickIdx;
  logic               w_any;
  logic [WORD_W-1:0]  w_pickWord;
  logic               w_start;
  logic               w_done;
  logic               w_abort;
  logic               w_timeout;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .clk_tck     (clk_tck),
    .reset       (reset),
    .req         (bus.req),
    .advance     (w_done),
    .advance_idx (r_ownerIdx),
    .pick_onehot (w_pickOnehot),
    .pick_idx    (w_pickIdx),
    .any         (w_any)
  );

`ifdef TDO_ARB_TIMEOUT_EN
  logic [WDOG_W-1:0] r_wdog;
  logic              r_timeoutErr;

  // Watchdog restarts on entry to SHIFT and counts every SHIFT cycle.
  always_ff @(posedge clk_tck) begin
    if (reset) begin
      r_wdog <= '0;
    end else if (r_state == LOAD) begin
      r_wdog <= '0;
    end else if (r_state == SHIFT) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_timeout = (r_state == SHIFT) && (r_wdog == WDOG_W'(TIMEOUT_CYC - 1));

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk_tck) begin
    if (reset) begin
      r_timeoutErr <= 1'b0;
    end else if (w_timeout && !bus.tx_done) begin
      r_timeoutErr <= 1'b1;
    end
  end

  assign bus.timeout_err = r_timeoutErr;
`else
  assign w_timeout = 1'b0;
`endif

  // A completed word always wins over an abort in the same cycle.
  assign w_start = (r_state == IDLE) && bus.shift_dr && w_any;
  assign w_done  = (r_state == SHIFT) && bus.tx_done;
  assign w_abort = (r_state == SHIFT) && !bus.tx_done && (!bus.shift_dr || w_timeout);

  // Select the winning requester's slice with a one-hot AND-OR mux.
  always_comb begin
    w_pickWord = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pickOnehot[i]) begin
        w_pickWord = bus.req_data[i*WORD_W +: WORD_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_tck) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic.
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE:  if (w_start) w_stateNext = LOAD;
      LOAD:  w_stateNext = SHIFT;
      SHIFT: begin
        if (w_done) begin
          w_stateNext = DONE;
        end else if (w_abort) begin
          w_stateNext = IDLE;
        end
      end
      DONE:  w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Next values for the registered outputs (grant, latched word, owner, abort pulse).
  always_comb begin
    w_grantNext   = r_grant;
    w_txDataNext  = r_txData;
    w_ownerNext   = r_ownerIdx;
    w_abortedNext = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_grantNext  = w_pickOnehot;
          w_txDataNext = w_pickWord;
          w_ownerNext  = w_pickIdx;
        end
      end
      SHIFT: begin
        if (w_abort) begin
          w_grantNext   = '0;
          w_abortedNext = 1'b1;
        end
      end
      DONE: w_grantNext = '0;
      default: ;
    endcase
  end

  // Output registers; reset drops everything silently without pulses.
  always_ff @(posedge clk_tck) begin
    if (reset) begin
      r_grant    <= '0;
      r_txData   <= '0;
      r_ownerIdx <= '0;
      r_aborted  <= 1'b0;
    end else begin
      r_grant    <= w_grantNext;
      r_txData   <= w_txDataNext;
      r_ownerIdx <= w_ownerNext;
      r_aborted  <= w_abortedNext;
    end
  end

  assign bus.grant     = r_grant;
  assign bus.ack       = (r_state == DONE) ? r_grant : '0;
  assign bus.aborted   = r_aborted;
  assign bus.tx_enable = (r_state == SHIFT);
  assign bus.tx_data   = r_txData;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_tdo_shift_arbiter.sv
// Self-checking bench for tdo_shift_arbiter with a behavioural round-robin model.
// Watchdog checks are included when TDO_ARB_TIMEOUT_EN is defined.
module tb_tdo_shift_arbiter;

  logic clk = 1'b0;
  logic reset;

  int assertCount = 0;
  int failCount   = 0;
  int mdlPtr      = 0;
  logic [3:0]  curReq;
  logic [31:0] slices [4];

  tdo_shift_arbiter_if #(.NUM_REQ(4), .WORD_W(32)) bus ();

  tdo_shift_arbiter #(.NUM_REQ(4), .WORD_W(32)) dut (
    .clk_tck (clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic sd, input logic [3:0] r);
    bus.shift_dr = sd;
    bus.req      = r;
    curReq       = r;
  endtask

  task automatic setSlice(input int idx, input logic [31:0] val);
    slices[idx] = val;
    bus.req_data[idx*32 +: 32] = val;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    bus.tx_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mdlPtr = 0;
  endtask

  // Winner = first requesting index at or after the model pointer, wrapping.
  function automatic int expectedPick(input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (mdlPtr + k) % 4;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  // One full word from arbitration to return to IDLE, checked against the model.
  task automatic doTransfer(input int doneDelay, input bit abortWithDone,
                            input bit dropEarly, input bit dropAfterAck);
    int owner;
    logic [3:0]  oh;
    logic [31:0] word;
    owner = expectedPick(curReq);
    oh    = 4'b0001 << owner;
    word  = slices[owner];
    tick();
    checkOutput("grant", 32'(bus.grant), 32'(oh));
    checkOutput("enable_low_load", 32'(bus.tx_enable), 32'd0);
    checkOutput("tx_data_latch", bus.tx_data, word);
    checkOutput("busy_load", 32'(bus.busy), 32'd1);
    if (dropEarly) applyStimulus(bus.shift_dr, curReq & ~oh);
    tick();
    checkOutput("enable_rise", 32'(bus.tx_enable), 32'd1);
    checkOutput("grant_shift", 32'(bus.grant), 32'(oh));
    setSlice(owner, $urandom());
    repeat (doneDelay - 1) tick();
    checkOutput("enable_hold", 32'(bus.tx_enable), 32'd1);
    checkOutput("ack_early", 32'(bus.ack), 32'd0);
    bus.tx_done = 1'b1;
    if (abortWithDone) bus.shift_dr = 1'b0;
    tick();
    bus.tx_done = 1'b0;
    checkOutput("ack_pulse", 32'(bus.ack), 32'(oh));
    checkOutput("grant_done", 32'(bus.grant), 32'(oh));
    checkOutput("enable_drop", 32'(bus.tx_enable), 32'd0);
    checkOutput("no_abort_done", 32'(bus.aborted), 32'd0);
    checkOutput("tx_data_hold", bus.tx_data, word);
    mdlPtr = (owner + 1) % 4;
    if (dropAfterAck) applyStimulus(bus.shift_dr, curReq & ~oh);
    tick();
    checkOutput("ack_single", 32'(bus.ack), 32'd0);
    checkOutput("grant_clear", 32'(bus.grant), 32'd0);
    checkOutput("busy_idle", 32'(bus.busy), 32'd0);
    checkOutput("no_abort_idle", 32'(bus.aborted), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_grant"}, 32'(bus.grant), 32'd0);
    checkOutput({tag, "_ack"}, 32'(bus.ack), 32'd0);
    checkOutput({tag, "_aborted"}, 32'(bus.aborted), 32'd0);
    checkOutput({tag, "_enable"}, 32'(bus.tx_enable), 32'd0);
    checkOutput({tag, "_data"}, bus.tx_data, 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.shift_dr = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_done  = 1'b0;
    curReq       = '0;
    for (int i = 0; i < 4; i++) slices[i] = '0;

    resetDut();
    checkAllZero("reset");

    // Single word, request dropped after grant, data changed after LOAD.
    for (int i = 0; i < 4; i++) setSlice(i, $urandom());
    setSlice(1, 32'hDEADBEEF);
    applyStimulus(1'b1, 4'b0010);
    doTransfer(33, 1'b0, 1'b1, 1'b0);

    // Round-robin fairness with all four requesting continuously.
    resetDut();
    setSlice(0, 32'h11111111);
    setSlice(1, 32'h22222222);
    setSlice(2, 32'h33333333);
    setSlice(3, 32'h44444444);
    applyStimulus(1'b1, 4'b1111);
    for (int w = 0; w < 5; w++) doTransfer($urandom_range(1, 40), 1'b0, 1'b0, 1'b0);

    // Abort of requester 2 ten cycles into SHIFT, then re-grant to the same one.
    resetDut();
    for (int i = 0; i < 4; i++) setSlice(i, $urandom());
    applyStimulus(1'b1, 4'b0010);
    doTransfer($urandom_range(1, 20), 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b0101);
    tick();
    checkOutput("abort_grant", 32'(bus.grant), 32'(4'b0100));
    tick();
    checkOutput("abort_enable", 32'(bus.tx_enable), 32'd1);
    repeat (9) tick();
    applyStimulus(1'b0, 4'b0101);
    tick();
    checkOutput("abort_enable_drop", 32'(bus.tx_enable), 32'd0);
    checkOutput("abort_pulse", 32'(bus.aborted), 32'd1);
    checkOutput("abort_no_ack", 32'(bus.ack), 32'd0);
    checkOutput("abort_grant_clear", 32'(bus.grant), 32'd0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    tick();
    checkOutput("abort_single_pulse", 32'(bus.aborted), 32'd0);
    checkOutput("abort_idle_grant", 32'(bus.grant), 32'd0);
    applyStimulus(1'b1, 4'b0101);
    doTransfer($urandom_range(1, 20), 1'b0, 1'b0, 1'b1);

    // Done and shift_dr drop on the same edge: done wins and pointer advances.
    resetDut();
    for (int i = 0; i < 4; i++) setSlice(i, $urandom());
    applyStimulus(1'b1, 4'b0011);
    doTransfer($urandom_range(1, 20), 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("sim_idle_grant", 32'(bus.grant), 32'd0);
    applyStimulus(1'b1, 4'b0011);
    doTransfer($urandom_range(1, 20), 1'b0, 1'b0, 1'b1);

    // Reset in the middle of SHIFT, then a normal transfer afterwards.
    resetDut();
    for (int i = 0; i < 4; i++) setSlice(i, $urandom());
    applyStimulus(1'b1, 4'b0001);
    tick();
    tick();
    repeat (14) tick();
    checkOutput("pre_reset_enable", 32'(bus.tx_enable), 32'd1);
    reset = 1'b1;
    tick();
    checkAllZero("midreset");
    reset = 1'b0;
    mdlPtr = 0;
    doTransfer($urandom_range(1, 40), 1'b0, 1'b0, 1'b1);

    // Randomized request patterns against the model.
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) setSlice(i, $urandom());
      applyStimulus(1'b1, 4'($urandom_range(1, 15)));
      doTransfer($urandom_range(1, 12), 1'b0, 1'b0, 1'b1);
    end

`ifdef TDO_ARB_TIMEOUT_EN
    // Serializer never finishes: watchdog aborts at SHIFT cycle 40.
    resetDut();
    checkOutput("timeout_reset", 32'(bus.timeout_err), 32'd0);
    applyStimulus(1'b1, 4'b1000);
    tick();
    tick();
    repeat (39) tick();
    checkOutput("timeout_not_yet", 32'(bus.tx_enable), 32'd1);
    checkOutput("timeout_err_not_yet", 32'(bus.timeout_err), 32'd0);
    tick();
    checkOutput("timeout_enable_drop", 32'(bus.tx_enable), 32'd0);
    checkOutput("timeout_aborted", 32'(bus.aborted), 32'd1);
    checkOutput("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    checkOutput("timeout_no_ack", 32'(bus.ack), 32'd0);
    applyStimulus(1'b0, 4'b0000);
    repeat (5) tick();
    checkOutput("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);
    resetDut();
    checkOutput("timeout_err_cleared", 32'(bus.timeout_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
